div5_seq_ctrl: RTL and testbench

// Sequential controller for a 5-bit unsigned restoring divider. It shares one
// cla5_bit adder instance, configured as a subtractor (B inverted, c0=1), across

---
 rtl/div5_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_div5_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div5_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div5_seq_ctrl (with helper cla5_bit)
// Brief    : 5-bit unsigned restoring divider sequencer, one quotient bit per
//            clock on a shared carry-lookahead subtractor.
// Revision : 1.0 - initial release
// ============================================================================

module cla5_bit (
    input  logic [4:0] i_a,
    input  logic [4:0] i_b,
    input  logic       i_c0,
    output logic [4:0] o_sum,
    output logic       o_c_out
);
    logic [4:0] w_g;
    logic [4:0] w_p;
    logic [5:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Flat lookahead carries: every carry is a two-level function of g/p/c0.
    assign w_c[0] = i_c0;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c[5] = w_g[4] | (w_p[4] & w_g[3]) | (w_p[4] & w_p[3] & w_g[2])
                  | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
                  | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (&w_p & i_c0);

    assign o_sum   = w_p ^ w_c[4:0];
    assign o_c_out = w_c[5];
endmodule

module div5_seq_ctrl #(
    parameter int               DATA_W       = 5,
    parameter logic [DATA_W-1:0] DBZ_QUOTIENT = 5'h1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic              busy
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ITER  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [2:0] c_LAST_STEP = 3'd4;

    logic [1:0]        r_state;
    logic [2:0]        r_count;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_quotient;
    logic [DATA_W-1:0] r_remainder;
    logic              r_dbz;
    logic              r_out_valid;

    logic [DATA_W:0]   w_s;
    logic [DATA_W-1:0] w_diff;
    logic              w_c_out;
    logic              w_ok;
    logic [DATA_W-1:0] w_r_next;
    logic [DATA_W-1:0] w_q_next;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign w_s = {r_r, r_q[DATA_W-1]};

    cla5_bit u_sub (
        .i_a     (w_s[DATA_W-1:0]),
        .i_b     (~r_d),
        .i_c0    (1'b1),
        .o_sum   (w_diff),
        .o_c_out (w_c_out)
    );

    // Bit 5 set means S >= 32 > D, so the subtraction always succeeds there.
    assign w_ok     = w_s[DATA_W] | w_c_out;
    assign w_r_next = w_ok ? w_diff : w_s[DATA_W-1:0];
    assign w_q_next = {r_q[DATA_W-2:0], w_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_count     <= 3'd0;
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_d     <= divisor;
                        r_q     <= dividend;
                        r_r     <= '0;
                        r_count <= 3'd0;
                        if (divisor == '0) begin
                            r_state     <= c_ST_DONE;
                            r_quotient  <= DBZ_QUOTIENT;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= c_ST_ITER;
                        end
                    end
                end
                c_ST_ITER: begin
                    r_r     <= w_r_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 3'd1;
                    if (r_count == c_LAST_STEP) begin
                        r_state     <= c_ST_DONE;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    // Divide-by-zero enters DONE with out_valid still low; raise it one edge later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == c_ST_IDLE);
    assign busy        = (r_state == c_ST_ITER);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
endmodule

`default_nettype wire

// File: tb/tb_div5_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div5_seq_ctrl
// Brief    : Directed vector table, reset/backpressure sequences and a full
//            operand sweep for div5_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================

module tb_div5_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        int         stall;
        logic [4:0] q;
        logic [4:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[9];

    div5_seq_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one full transaction; entered and left 1ns after a rising edge.
    task automatic do_op(input logic [4:0] a, input logic [4:0] b, input int stall,
                         input logic [4:0] eq, input logic [4:0] er, input logic edbz,
                         input string name);
        int wait_n;
        int lat;
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check({name, ".in_ready_before"}, int'(in_ready), 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 5'h0A;
        divisor  = 5'h00;
        check({name, ".in_ready_after_accept"}, int'(in_ready), 0);
        check({name, ".busy_after_accept"}, int'(busy), edbz ? 0 : 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, ".latency"}, lat, edbz ? 1 : 5);
        check({name, ".quotient"}, int'(quotient), int'(eq));
        check({name, ".remainder"}, int'(remainder), int'(er));
        check({name, ".div_by_zero"}, int'(div_by_zero), int'(edbz));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({name, ".stall_valid"}, int'(out_valid), 1);
            check({name, ".stall_in_ready"}, int'(in_ready), 0);
            check({name, ".stall_result"}, int'({quotient, remainder, div_by_zero}),
                  int'({eq, er, edbz}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".valid_dropped"}, int'(out_valid), 0);
        check({name, ".in_ready_after"}, int'(in_ready), 1);
        check({name, ".result_held"}, int'({quotient, remainder, div_by_zero}),
              int'({eq, er, edbz}));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 5'd23, b: 5'd5,  stall: 0, q: 5'd4,  r: 5'd3, dbz: 1'b0};
        vecs[1] = '{a: 5'd31, b: 5'd1,  stall: 0, q: 5'd31, r: 5'd0, dbz: 1'b0};
        vecs[2] = '{a: 5'd31, b: 5'd31, stall: 1, q: 5'd1,  r: 5'd0, dbz: 1'b0};
        vecs[3] = '{a: 5'd4,  b: 5'd9,  stall: 0, q: 5'd0,  r: 5'd4, dbz: 1'b0};
        vecs[4] = '{a: 5'd0,  b: 5'd7,  stall: 2, q: 5'd0,  r: 5'd0, dbz: 1'b0};
        vecs[5] = '{a: 5'd7,  b: 5'd0,  stall: 0, q: 5'd31, r: 5'd7, dbz: 1'b1};
        vecs[6] = '{a: 5'd16, b: 5'd2,  stall: 0, q: 5'd8,  r: 5'd0, dbz: 1'b0};
        vecs[7] = '{a: 5'd30, b: 5'd7,  stall: 0, q: 5'd4,  r: 5'd2, dbz: 1'b0};
        vecs[8] = '{a: 5'd17, b: 5'd3,  stall: 4, q: 5'd5,  r: 5'd2, dbz: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 5'd0;
        divisor   = 5'd0;
        #1;
        check("reset.in_ready", int'(in_ready), 1);
        check("reset.outputs", int'({out_valid, busy, div_by_zero, quotient, remainder}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].q, vecs[i].r, vecs[i].dbz,
                  $sformatf("vec%0d", i));

        // Asynchronous reset three steps into 29/4 aborts the operation.
        dividend = 5'd29;
        divisor  = 5'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset.in_ready", int'(in_ready), 1);
        check("midreset.outputs", int'({out_valid, busy, div_by_zero, quotient, remainder}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("midreset.no_valid", int'(out_valid), 0);
        end
        do_op(5'd12, 5'd5, 0, 5'd2, 5'd2, 1'b0, "after_reset");

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                if (b == 0)
                    do_op(5'(a), 5'(b), int'($urandom_range(0, 2)), 5'd31, 5'(a), 1'b1, "sweep");
                else
                    do_op(5'(a), 5'(b), int'($urandom_range(0, 2)), 5'(a / b), 5'(a % b), 1'b0,
                          "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
